// File: rtl/esp_uart_regs_if.sv
// CPU bus link between the interconnect (master) and the UART register block (slave).
// Signals: bus_addr (word select), bus_wrdata, bus_bytesel, bus_wren, bus_strobe
// from the master; bus_wait (stall) and bus_rddata (read data) from the slave.
interface esp_uart_regs_if;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wrdata;
    logic [3:0]  bus_bytesel;
    logic        bus_wren;
    logic        bus_strobe;
    logic        bus_wait;
    logic [31:0] bus_rddata;

    modport master (
        output bus_addr, bus_wrdata, bus_bytesel, bus_wren, bus_strobe,
        input  bus_wait, bus_rddata
    );

    modport slave (
        input  bus_addr, bus_wrdata, bus_bytesel, bus_wren, bus_strobe,
        output bus_wait, bus_rddata
    );
endinterface

// File: rtl/esp_uart_regs.sv
// Memory-mapped register window over the ESP32 UART FIFOs.
// Ports:
//   clk, reset_n         - system clock, synchronous active-low reset
//   bus                  - CPU bus slave (addr/wrdata/bytesel/wren/strobe in, wait/rddata out)
//   irq                  - registered level interrupt
//   txfifo_data/wr/full  - TX FIFO push side
//   rxfifo_data/rd/empty - RX FIFO show-ahead pop side
//   rxfifo_overflow, rx_framing_error - single-cycle error events
module esp_uart_regs (
    input  logic        clk,
    input  logic        reset_n,
    esp_uart_regs_if.slave bus,
    output logic        irq,
    output logic [8:0]  txfifo_data,
    output logic        txfifo_wr,
    input  logic        txfifo_full,
    input  logic [8:0]  rxfifo_data,
    output logic        rxfifo_rd,
    input  logic        rxfifo_empty,
    input  logic        rxfifo_overflow,
    input  logic        rx_framing_error
);
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQEN  = 2'd2;

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic        pop;
    logic        ovf_sticky;
    logic        fe_sticky;
    logic [2:0]  irq_en;
    logic [31:0] rddata;
    logic [31:0] rd_mux;

    logic rd_req;
    logic wr_req;
    logic wr_status;
    logic wr_irqen;
    logic unused_bits;

    // Strobes are gated by reset so nothing leaks to the bus or FIFOs during reset.
    assign rd_req    = reset_n && bus.bus_strobe && (state == IDLE) && !bus.bus_wren;
    assign wr_req    = reset_n && bus.bus_strobe && (state == IDLE) && bus.bus_wren;
    assign wr_status = wr_req && (bus.bus_addr == ADDR_STATUS);
    assign wr_irqen  = wr_req && (bus.bus_addr == ADDR_IRQEN);

    // Reads stall for the capture cycle; DATA writes stall while the TX FIFO is full.
    assign bus.bus_wait   = rd_req || (wr_req && (bus.bus_addr == ADDR_DATA) && txfifo_full);
    assign txfifo_wr      = wr_req && (bus.bus_addr == ADDR_DATA) && !txfifo_full;
    assign rxfifo_rd      = reset_n && (state == RESP) && pop;
    assign txfifo_data    = bus.bus_wrdata[8:0];
    assign bus.bus_rddata = rddata;

    assign unused_bits = ^{bus.bus_bytesel, bus.bus_wrdata[31:9]};

    // Read data selection from the current register contents and FIFO flags.
    always_comb begin
        rd_mux = 32'h0;
        case (bus.bus_addr)
            ADDR_DATA:   rd_mux = {22'h0, !rxfifo_empty, rxfifo_data};
            ADDR_STATUS: rd_mux = {28'h0, fe_sticky, ovf_sticky, txfifo_full, !rxfifo_empty};
            ADDR_IRQEN:  rd_mux = {29'h0, irq_en};
            default:     rd_mux = 32'h0;
        endcase
    end

    // Read FSM, sticky flags, interrupt enables and interrupt register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pop        <= 1'b0;
            rddata     <= 32'h0;
            irq        <= 1'b0;
            ovf_sticky <= 1'b0;
            fe_sticky  <= 1'b0;
            irq_en     <= 3'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        rddata <= rd_mux;
                        pop    <= (bus.bus_addr == ADDR_DATA) && !rxfifo_empty;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    pop   <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A new event in the same cycle as a clear keeps the flag set.
            ovf_sticky <= rxfifo_overflow  || (ovf_sticky && !(wr_status && bus.bus_wrdata[2]));
            fe_sticky  <= rx_framing_error || (fe_sticky  && !(wr_status && bus.bus_wrdata[3]));

            if (wr_irqen) begin
                irq_en <= bus.bus_wrdata[2:0];
            end

            irq <= (irq_en[0] && !rxfifo_empty) ||
                   (irq_en[1] && !txfifo_full) ||
                   (irq_en[2] && (ovf_sticky || fe_sticky));
        end
    end
endmodule

// File: doc/esp_uart_regs.md
# esp_uart_regs

Memory-mapped CPU-bus responder exposing the ESP32 UART FIFOs (aqp_esp_uart) to the aq32 CPU. It decodes a 16-byte register window, completes each bus transaction with the CPU bus wait/strobe handshake, pops RX bytes on completed data reads, stalls writes while the TX FIFO is full, and raises a level interrupt. It sits between the CPU bus interconnect and aqp_esp_uart.

## Interface
- No parameters.
- `clk` in 1: system clock, 28.63636 MHz.
- `reset_n` in 1: synchronous, active-low reset.
- `bus_addr` in 2: word select, CPU address bits [3:2].
- `bus_wrdata` in 32: write data.
- `bus_bytesel` in 4: byte enables. Ignored; all accesses act on the full register.
- `bus_wren` in 1: 1 for write, 0 for read.
- `bus_strobe` in 1: access to this block (already decoded by the interconnect).
- `bus_wait` out 1: stall. Combinational.
- `bus_rddata` out 32: read data. Registered.
- `irq` out 1: level interrupt. Registered.
- `txfifo_data` out 9: TX byte, taken from `bus_wrdata[8:0]`.
- `txfifo_wr` out 1: TX push strobe. Combinational.
- `txfifo_full` in 1: TX FIFO full.
- `rxfifo_data` in 9: RX FIFO head (show-ahead). Valid while `!rxfifo_empty`.
- `rxfifo_rd` out 1: RX pop strobe. Combinational.
- `rxfifo_empty` in 1: RX FIFO empty.
- `rxfifo_overflow` in 1: single-cycle RX overflow event.
- `rx_framing_error` in 1: single-cycle framing-error event.

## Operation
- A transaction completes in the cycle where `bus_strobe && !bus_wait`. The CPU holds addr, wrdata and wren stable while `bus_wait` is 1.
- Register map (`bus_addr`):
  - 0, DATA.
    - Read returns `{22'b0, rx_valid, rxfifo_data}`, where `rx_valid = !rxfifo_empty`. If `rx_valid` was 1 when the read was captured, the byte is popped.
    - Write pushes `bus_wrdata[8:0]`.
  - 1, STATUS.
    - Read returns `{28'b0, fe_sticky, ovf_sticky, txfifo_full, !rxfifo_empty}`.
    - Write: 1 in bit 2 clears `ovf_sticky`; 1 in bit 3 clears `fe_sticky`.
  - 2, IRQ_EN.
    - Read/write bits [2:0]: en_rx, en_tx, en_err. Other bits read 0.
  - 3, reserved. Reads 0; writes are ignored.
- The read state machine has two states, IDLE and RESP.
  - IDLE + strobe + !wren: capture the read data into `bus_rddata`, latch a pop flag (DATA && rx_valid), assert `bus_wait`, go to RESP.
  - RESP: `bus_wait`=0 and the transaction completes. `rxfifo_rd` = the pop flag. Return to IDLE unconditionally.
  - If strobe is still asserted in the next IDLE cycle, that is a new transaction.
- Writes are handled in IDLE only and never pass through RESP.
  - DATA write with `txfifo_full`=1: `bus_wait`=1, no push. The write completes in the first cycle where `txfifo_full`=0; `txfifo_wr`=1 in that same cycle. There is no timeout.
  - Write to any other register: `bus_wait`=0, takes effect at the next edge.
- Sticky bits are set by their event input and cleared by write-1. When a set and a clear occur in the same cycle, the set wins.
- `irq` next = `(en_rx & !rxfifo_empty) | (en_tx & !txfifo_full) | (en_err & (ovf_sticky | fe_sticky))`.
- Reset (`reset_n`=0 at a clk edge) forces the following values, including mid-transaction:
  - state IDLE, no pop
  - `bus_rddata`=0, `irq`=0
  - sticky bits 0, IRQ_EN 0
  - `bus_wait`/`txfifo_wr`/`rxfifo_rd` evaluate to 0 until a new strobe arrives

## Timing
- Read latency: 2 cycles (one wait cycle, then completion). `bus_rddata` is valid during the completion cycle and held until the next read capture.
- The RX pop takes effect at the completion-cycle edge. A back-to-back DATA read then sees the next head.
- Writes: 1 cycle when not stalled. A stalled DATA write completes in the same cycle `txfifo_full` falls.
- `irq` lags its sources by 1 cycle.
- STATUS reflects FIFO flags as sampled in the capture cycle. Sticky bits reflect events up to the previous edge.

## Test plan
- Reset: hold `reset_n`=0 with strobe active → `bus_wait`=0, `rxfifo_rd`=0, `txfifo_wr`=0, `irq`=0, `bus_rddata`=0.
- RX head 0x041 loaded, read DATA → wait=1 for one cycle, then `bus_rddata`=0x00000241 with `rxfifo_rd`=1 in the completion cycle. Second read with the FIFO empty → 0x00000000 and no pop.
- `txfifo_full`=1, write DATA 0x1A5 → `bus_wait`=1 for 5 cycles. Drop full → same cycle `txfifo_wr`=1, `txfifo_data`=0x1A5, wait=0. Exactly one push.
- Pulse `rxfifo_overflow` → STATUS reads 0x4 (bit 2). Write STATUS 0x4 in the same cycle as a new overflow pulse → bit remains 1. Plain clear → reads 0.
- IRQ_EN=0x1, RX non-empty → `irq`=1 one cycle later. Pop the last byte → `irq`=0 one cycle after empty.
- Assert `reset_n`=0 during the RESP cycle of a DATA read → no `rxfifo_rd`, IRQ_EN reads 0 afterwards, next read behaves normally.
